// File: rtl/flag_cond_resolver.sv
// flag_cond_resolver: resolves B.cond / CBZ in decode against the NZCV flags.
// A B.cond behind a flag-setting EX instruction interlocks for one cycle
// instead of bypassing. The decision is registered as a one-cycle pulse,
// and resolved and taken branches are counted.
module flag_cond_resolver #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       flags_q,
  input  logic             ex_setflags,
  input  logic             dec_valid,
  input  logic             dec_is_bcond,
  input  logic             dec_is_cbz,
  input  logic [3:0]       dec_cond,
  input  logic             dec_zero,
  input  logic             flush,
  output logic             stall,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cond_hold_q, cond_hold_d;
  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic             stall_c;
  logic             resolve;
  logic             taken;

  // Condition-code evaluation; flags are {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = !cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cy && !z;
      4'b1001: cond_eval = !cy || z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z && (n == v);
      4'b1101: cond_eval = z || (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Next-state, interlock and resolve decision.
  always_comb begin
    state_d     = state_q;
    cond_hold_d = cond_hold_q;
    stall_c     = 1'b0;
    resolve     = 1'b0;
    taken       = 1'b0;
    case (state_q)
      IDLE: begin
        if (dec_valid && !flush && (dec_is_bcond || dec_is_cbz)) begin
          if (dec_is_cbz) begin
            resolve = 1'b1;
            taken   = dec_zero;
          end else if (ex_setflags) begin
            stall_c     = 1'b1;
            cond_hold_d = dec_cond;
            state_d     = WAIT;
          end else begin
            resolve = 1'b1;
            taken   = cond_eval(dec_cond, flags_q);
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
        if (!flush) begin
          resolve = 1'b1;
          taken   = cond_eval(cond_hold_q, flags_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered result and statistics updates.
  always_comb begin
    br_valid_d    = resolve;
    br_taken_d    = resolve && taken;
    br_count_d    = br_count_q + {{(CNT_W-1){1'b0}}, resolve};
    taken_count_d = taken_count_q + {{(CNT_W-1){1'b0}}, resolve && taken};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cond_hold_q   <= '0;
      br_valid_q    <= 1'b0;
      br_taken_q    <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cond_hold_q   <= cond_hold_d;
      br_valid_q    <= br_valid_d;
      br_taken_q    <= br_taken_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign stall       = stall_c && !rst;
  assign br_valid    = br_valid_q;
  assign br_taken    = br_taken_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule

// File: doc/flag_cond_resolver.md
# flag_cond_resolver

Consumer of the NZCV flag register: resolves B.cond and CBZ decisions in decode for the pipelined CPU. Reads the architectural flags written by the per-bit flag register cells. When a flag-setting instruction is still in EX, it interlocks for one cycle instead of bypassing. Emits a registered one-cycle taken/not-taken result to the fetch/PC logic and keeps branch statistics counters.

## Interface
- CNT_W, 16, width of both statistics counters

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flags_q  in  4  architectural flags, [3]=N [2]=Z [1]=C [0]=V; updated at the posedge ending an EX setflags instruction
- ex_setflags  in  1  instruction currently in EX will write flags at this cycle's closing edge
- dec_valid  in  1  decode stage holds a valid instruction
- dec_is_bcond  in  1  decode instruction is B.cond
- dec_is_cbz  in  1  decode instruction is CBZ
- dec_cond  in  4  B.cond condition field
- dec_zero  in  1  forwarded CBZ register operand equals zero
- flush  in  1  squash decode-stage branch (redirect from later stage)
- stall  out  1  hold fetch/decode and inject a bubble into EX (combinational)
- br_valid  out  1  registered; one-cycle pulse, decision available
- br_taken  out  1  registered; decision, meaningful only when br_valid=1
- br_count  out  CNT_W  resolved branches (B.cond + CBZ)
- taken_count  out  CNT_W  resolved branches that were taken

## Operation
- Condition eval, cond(c, N,Z,C,V): EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 and NV 1111 always 1.
- dec_is_bcond and dec_is_cbz never both 1; if so, CBZ takes priority.
- FSM states: IDLE, WAIT. Captured register: cond_hold[3:0].
- IDLE, req = dec_valid & !flush & (dec_is_bcond | dec_is_cbz):
  - CBZ: resolve now, taken=dec_zero; stay IDLE.
  - B.cond & !ex_setflags: resolve now, taken=cond(dec_cond, flags_q); stay IDLE.
  - B.cond & ex_setflags: stall=1, cond_hold<=dec_cond, go WAIT; no resolve.
  - no req: nothing.
- WAIT: stall=0. dec_*, ex_setflags ignored.
  - !flush: resolve with taken=cond(cond_hold, flags_q); go IDLE.
  - flush: no resolve; go IDLE.
- Resolve at edge: br_valid<=1, br_taken<=taken, br_count+=1, taken_count+=taken. Otherwise br_valid<=0, br_taken<=0.
- Counters wrap modulo 2^CNT_W (all-ones + 1 -> 0), no saturation.
- rst (any state, overrides everything): state IDLE, cond_hold 0, br_valid 0, br_taken 0, br_count 0, taken_count 0. stall forced 0 while rst=1.

## Timing
- Unstalled B.cond/CBZ in decode cycle T: br_valid=1 during T+1. Latency 1.
- Interlocked B.cond in cycle T: stall=1 in T only. Resolution in T+1 uses the flags written at the end of T. br_valid=1 during T+2. Latency 2.
- Back-to-back branches in consecutive unstalled cycles give consecutive br_valid pulses. No dead cycle.
- A B.cond decoded in the cycle after the WAIT cycle is a new request with normal rules.
- flush in the same cycle as a request: request dropped, stall=0, no counter change.
- stall is a pure function of state, inputs and rst. Never asserted in WAIT, so the maximum stall per branch is 1 cycle.
- rst asserted in WAIT: the pending branch is discarded; the next cycle is IDLE with all outputs 0.

## Test plan
- Reset, then flags_q=0100 (Z=1), B.cond EQ with ex_setflags=0 -> br_valid=1, br_taken=1 next cycle; br_count=1, taken_count=1, stall stays 0.
- Sweep all 16 dec_cond values against all 16 flags_q values, unstalled -> br_taken matches the condition table for every pair (256 checks); NV and AL always taken.
- B.cond GE with ex_setflags=1 and flags_q=1000 (N=1,V=0); flags_q becomes 1001 at that edge -> stall=1 for one cycle, then br_valid=1 with br_taken=1 two cycles after the request.
- Interlocked B.cond with flush=1 in the WAIT cycle -> no br_valid, counters unchanged, state IDLE. Repeat with rst=1 in WAIT -> all outputs 0.
- CBZ with ex_setflags=1, dec_zero=1 -> no stall, br_taken=1 next cycle. CBZ with dec_zero=0 -> br_taken=0, taken_count unchanged.
- CNT_W=4: 16 consecutive taken branches -> br_count and taken_count go 15 -> 0, and br_valid pulses every cycle.
